// File: rtl/edge_recon.sv
// Edge-pulse to level reconstructor with a minimum hold time and a one-deep pending request.
// Optional sticky protocol-error flag (err_o, err_clr_i) is built when EDGE_RECON_ERR_EN is defined.
module edge_recon #(
    parameter int MIN_HOLD = 2,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rise_i,
    input  logic fall_i,
`ifdef EDGE_RECON_ERR_EN
    input  logic err_clr_i,
    output logic err_o,
`endif
    output logic a_o,
    output logic busy_o
);

    typedef enum logic [1:0] {LOW, HOLD_HI, HIGH, HOLD_LO} state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MIN_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             a_q, a_d;

    logic req, same, opp, hold, settled;

    // Requests are judged against the level held before this edge; pending is always opposite to it.
    assign req     = rise_i ^ fall_i;
    assign same    = req & (rise_i == a_q);
    assign opp     = req & (rise_i != a_q);
    assign hold    = (state_q == HOLD_HI) || (state_q == HOLD_LO);
    assign settled = !hold || ((cnt_q == '0) && !pend_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (settled) begin
            if (opp) begin
                state_d = a_q ? HOLD_LO : HOLD_HI;
                cnt_d   = RELOAD;
            end else if (hold) begin
                state_d = a_q ? HIGH : LOW;
            end
        end else begin
            if (pend_q && same) begin
                pend_d = 1'b0;
            end else if (!pend_q && opp) begin
                pend_d = 1'b1;
            end
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else if (pend_d) begin
                state_d = a_q ? HOLD_LO : HOLD_HI;
                cnt_d   = RELOAD;
                pend_d  = 1'b0;
            end else begin
                state_d = a_q ? HIGH : LOW;
            end
        end
        a_d = (state_d == HOLD_HI) || (state_d == HIGH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            a_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
        end
    end

    assign a_o    = a_q;
    assign busy_o = pend_q | (cnt_q != '0);

`ifdef EDGE_RECON_ERR_EN
    logic err_q, err_d, err_evt;

    // Both pulses at once, a request matching the held level, or a duplicate of the pending one.
    assign err_evt = (rise_i & fall_i) | (same & (settled | ~pend_q)) | (opp & ~settled & pend_q);
    assign err_d   = (err_q & ~err_clr_i) | err_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule
